// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the ALU/LSU requesters, the issue stage and the
// register-file arbiter. The arbiter uses the slave modport.
interface regfile_wb_arbiter_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [DW-1:0]   alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [DW-1:0]   lsu_data;
  logic            lsu_ready;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            rf_write_en;
  logic [AW-1:0]   rf_reg_dest;
  logic [DW-1:0]   rf_write_back;
  logic [NREG-1:0] busy;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd,
    input  alu_ready, lsu_ready, rf_write_en, rf_reg_dest, rf_write_back, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd,
    output alu_ready, lsu_ready, rf_write_en, rf_reg_dest, rf_write_back, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port (ALU vs LSU)
// with a per-register pending-write busy scoreboard for RAW stalls.
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_LSU = 1'b1
  } prio_e;

  prio_e           prio_q, prio_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   dest_q, dest_d;
  logic [DW-1:0]   data_q, data_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic alu_req, lsu_req, alu_x0, lsu_x0;
  logic grant_alu, grant_lsu;

  // x0 requests never compete: they are acknowledged and silently dropped.
  assign alu_x0  = bus.alu_valid && (bus.alu_rd == '0);
  assign lsu_x0  = bus.lsu_valid && (bus.lsu_rd == '0);
  assign alu_req = bus.alu_valid && (bus.alu_rd != '0);
  assign lsu_req = bus.lsu_valid && (bus.lsu_rd != '0);

  assign grant_alu = !rst && alu_req && (!lsu_req || prio_q == PRIO_ALU);
  assign grant_lsu = !rst && lsu_req && (!alu_req || prio_q == PRIO_LSU);

  assign bus.alu_ready = !rst && (alu_x0 || grant_alu);
  assign bus.lsu_ready = !rst && (lsu_x0 || grant_lsu);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the ifs leaves a variable unassigned and no latch is inferred.
    prio_d = prio_q;
    wen_d  = 1'b0;
    dest_d = dest_q;
    data_d = data_q;
    if (grant_alu) begin
      prio_d = PRIO_LSU;
      wen_d  = 1'b1;
      dest_d = bus.alu_rd;
      data_d = bus.alu_data;
    end else if (grant_lsu) begin
      prio_d = PRIO_ALU;
      wen_d  = 1'b1;
      dest_d = bus.lsu_rd;
      data_d = bus.lsu_data;
    end

    // Clear on commit first, then set, so a newer in-flight writer wins.
    busy_d = busy_q;
    if (wen_q) busy_d[dest_q] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != '0) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge
    // values regardless of statement order.
    if (rst) begin
      prio_q <= PRIO_ALU;
      wen_q  <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      prio_q <= prio_d;
      wen_q  <= wen_d;
      dest_q <= dest_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign bus.rf_write_en   = wen_q;
  assign bus.rf_reg_dest   = dest_q;
  assign bus.rf_write_back = data_q;
  assign bus.busy          = busy_q;

endmodule
